// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding,
// pipeline constants and a saturating increment helper.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_STALL    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // First fetch address after reset.
    localparam logic [31:0] RESET_PC  = 32'h00000000;

    // States in which halt/branch/load-use/imem events are evaluated.
    function automatic logic evt_state(input state_t s);
        return (s == ST_RUN) || (s == ST_STALL) || (s == ST_WAIT_MEM);
    endfunction

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counters for the fetch controller.
// Only instantiated when FETCH_CTRL_PERF_EN is defined.
module fetch_perf_cnt
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        wait_evt,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_cycles
);

    // Count each event class; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles    <= '0;
            flush_count     <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (stall_evt) stall_cycles    <= sat_inc(stall_cycles);
            if (flush_evt) flush_count     <= sat_inc(flush_count);
            if (wait_evt)  mem_wait_cycles <= sat_inc(mem_wait_cycles);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: steers PC and IF/ID/ID-EX enables and flushes for
// redirects, load-use stalls, instruction-memory waits and halt.
// A taken branch is acted on in the same cycle; the other events take
// effect through the STALL, WAIT_MEM and HALT states.
// Optional macro FETCH_CTRL_PERF_EN adds saturating perf counter outputs.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    input  logic        load_use_d,
    input  logic        imem_ready,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic        mem_err
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_cycles
`endif
);

    localparam int          TMO_W       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W + 1)'(MEM_TIMEOUT);
    localparam logic [1:0]  FLUSH_EXTRA = 2'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [1:0]       flush_cnt;
    logic [TMO_W-1:0] timer;
    logic [TMO_W:0]   timer_inc;
    logic [31:0]      pc_target_q;
    logic             do_redirect;

    assign timer_inc = {1'b0, timer} + (TMO_W + 1)'(1);

    // Halt outranks a branch, so a redirect only happens when no halt is pending.
    assign do_redirect = rst && evt_state(state) && !halt_req && branch_taken_e;

    // The redirect target is visible in the same cycle it is resolved.
    assign pc_target = do_redirect ? branch_target_e : pc_target_q;

    // Decode the current state (and a same-cycle redirect) into pipeline controls.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (do_redirect) begin
            pc_en      = 1'b1;
            pc_sel     = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
                ST_STALL: begin
                    idex_flush = 1'b1;
                end
                ST_WAIT_MEM: begin
                    // PC and IF/ID frozen, nothing flushed.
                end
                ST_FLUSH: begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
                ST_HALT: begin
                    ifid_flush = 1'b1;
                    halted     = 1'b1;
                end
                default: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            endcase
        end
    end

    // State, flush down-counter, imem wait timer, redirect target and sticky error.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state       <= ST_RUN;
            flush_cnt   <= 2'd0;
            timer       <= '0;
            pc_target_q <= RESET_PC;
            mem_err     <= 1'b0;
        end else begin
            if (do_redirect) pc_target_q <= branch_target_e;
            unique case (state)
                ST_RUN, ST_STALL, ST_WAIT_MEM: begin
                    if (halt_req) begin
                        state <= ST_HALT;
                        timer <= '0;
                    end else if (branch_taken_e) begin
                        timer <= '0;
                        if (FLUSH_CYCLES > 1) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_EXTRA;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (load_use_d && state != ST_STALL) begin
                        // A load-use still asserted in STALL must not stretch the stall.
                        state <= ST_STALL;
                        timer <= '0;
                    end else if (!imem_ready) begin
                        if (state == ST_WAIT_MEM) begin
                            if (timer_inc >= TMO_LIMIT) begin
                                state   <= ST_HALT;
                                mem_err <= 1'b1;
                                timer   <= '0;
                            end else begin
                                timer <= timer_inc[TMO_W-1:0];
                            end
                        end else begin
                            state <= ST_WAIT_MEM;
                            timer <= '0;
                        end
                    end else begin
                        state <= ST_RUN;
                        timer <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= 2'd1) begin
                        state     <= ST_RUN;
                        flush_cnt <= 2'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic stall_evt;
    logic wait_evt;

    // Classify the cycle for the perf counters; a redirect overrides stall/wait.
    always_comb begin
        stall_evt = rst && !do_redirect && (state == ST_STALL);
        wait_evt  = rst && !do_redirect && (state == ST_WAIT_MEM);
    end

    fetch_perf_cnt u_perf (
        .clk             (clk),
        .rst             (rst),
        .stall_evt       (stall_evt),
        .flush_evt       (do_redirect),
        .wait_evt        (wait_evt),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );
`endif

endmodule
